// File: rtl/hazard_pkg.sv
// Shared constants and parameter sanity helpers for the hazard unit.
package hazard_pkg;

  // Operand forwarding selects
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // PCSrc value meaning "fall through, no redirect"
  localparam logic [1:0] PCSRC_SEQ = 2'b00;

  localparam int FETCH_LAT_MAX = 4;
  localparam int MC_LAT_MIN    = 1;
  localparam int MC_LAT_MAX    = 16;

  function automatic bit fetch_lat_ok(input int lat);
    return (lat >= 0) && (lat <= FETCH_LAT_MAX);
  endfunction

  function automatic bit mc_lat_ok(input int lat);
    return (lat >= MC_LAT_MIN) && (lat <= MC_LAT_MAX);
  endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Datapath <-> hazard unit signal bundle. The datapath is the master,
// the hazard unit the slave.
interface hazard_unit_mc_if #(parameter int AW = 5);
  logic [AW-1:0] Rs1_D, Rs2_D;
  logic [AW-1:0] Rs1_E, Rs2_E, Rd_E;
  logic [AW-1:0] Rd_M, Rd_W;
  logic [1:0]    PCSrc_E;
  logic          ResultSrc_E_0, ResultSrc_M_0;
  logic          RegWrite_M, RegWrite_W;
  logic          MCStart_E;
  logic          Stall_F, Stall_D, Stall_E;
  logic          Flush_D, Flush_E, Flush_M;
  logic [1:0]    ForwardA_E, ForwardB_E;
  logic          MC_Busy;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, PCSrc_E,
           ResultSrc_E_0, ResultSrc_M_0, RegWrite_M, RegWrite_W, MCStart_E,
    input  Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M,
           ForwardA_E, ForwardB_E, MC_Busy
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W, PCSrc_E,
           ResultSrc_E_0, ResultSrc_M_0, RegWrite_M, RegWrite_W, MCStart_E,
    output Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Flush_M,
           ForwardA_E, ForwardB_E, MC_Busy
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one E-stage source operand; M wins over W.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] Rs_i,
  input  logic [AW-1:0] Rd_M_i,
  input  logic [AW-1:0] Rd_W_i,
  input  logic          RegWrite_M_i,
  input  logic          RegWrite_W_i,
  output logic [1:0]    Fwd_o
);

  // x0 is never forwarded: it always reads as zero from the register file
  always_comb begin
    Fwd_o = FWD_RF;
    if (Rs_i != '0) begin
      if (RegWrite_M_i && (Rs_i == Rd_M_i))      Fwd_o = FWD_M;
      else if (RegWrite_W_i && (Rs_i == Rd_W_i)) Fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage core: forwarding, load-use stalls,
// redirect flushes stretched over the fetch BRAM latency, and E-stage
// holding for multi-cycle (mul/div) ops.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int AW        = 5,
  parameter int FETCH_LAT = 1,
  parameter int MC_LAT    = 4
) (
  input  logic             clk,
  input  logic             reset,
  hazard_unit_mc_if.slave  hif
);

  if (!fetch_lat_ok(FETCH_LAT)) begin : g_bad_fetch_lat
    $error("hazard_unit_mc: FETCH_LAT out of range 0..4");
  end
  if (!mc_lat_ok(MC_LAT)) begin : g_bad_mc_lat
    $error("hazard_unit_mc: MC_LAT out of range 1..16");
  end

  localparam int CW = $clog2(MC_LAT) + 1;
  // Last count before the op is allowed to leave E
  localparam logic [CW-1:0] CNT_LAST = (MC_LAT > 1) ? CW'(MC_LAT - 2) : '0;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam bit            MC_EN    = (MC_LAT > 1);

  logic          redir, lw_stall, mc_stall, flush_hold;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] mc_cnt_q, mc_cnt_d;
  logic          mc_rel_q, mc_rel_d;

  assign redir = (hif.PCSrc_E != PCSRC_SEQ);

  assign lw_stall =
      (hif.ResultSrc_E_0 && (hif.Rd_E != '0) &&
       ((hif.Rs1_D == hif.Rd_E) || (hif.Rs2_D == hif.Rd_E))) ||
      (hif.ResultSrc_M_0 && (hif.Rd_M != '0) &&
       ((hif.Rs1_D == hif.Rd_M) || (hif.Rs2_D == hif.Rd_M)));

  // The release cycle lets the op leave E even though MCStart_E is still high
  assign mc_stall = MC_EN && hif.MCStart_E && !mc_rel_q && !redir;

  hazard_fwd_sel #(.AW(AW)) u_fwd_a (
    .Rs_i         (hif.Rs1_E),
    .Rd_M_i       (hif.Rd_M),
    .Rd_W_i       (hif.Rd_W),
    .RegWrite_M_i (hif.RegWrite_M),
    .RegWrite_W_i (hif.RegWrite_W),
    .Fwd_o        (fwd_a)
  );

  hazard_fwd_sel #(.AW(AW)) u_fwd_b (
    .Rs_i         (hif.Rs2_E),
    .Rd_M_i       (hif.Rd_M),
    .Rd_W_i       (hif.Rd_W),
    .RegWrite_M_i (hif.RegWrite_M),
    .RegWrite_W_i (hif.RegWrite_W),
    .Fwd_o        (fwd_b)
  );

  // Redirect history: a 1 in any bit means the fetched word is still stale
  if (FETCH_LAT > 0) begin : g_flush_sr
    logic [FETCH_LAT-1:0] flush_sr_q, flush_sr_d;

    assign flush_sr_d = (flush_sr_q << 1) | FETCH_LAT'(redir);
    assign flush_hold = |flush_sr_q;

    // Shift register holding the last FETCH_LAT redirect bits
    always_ff @(posedge clk) begin
      if (!reset) flush_sr_q <= '0;
      else        flush_sr_q <= flush_sr_d;
    end
  end else begin : g_no_flush_sr
    assign flush_hold = 1'b0;
  end

  // Multi-cycle counter next state; a redirect or an idle E clears it
  always_comb begin
    mc_cnt_d = '0;
    mc_rel_d = 1'b0;
    if (mc_stall) begin
      if (mc_cnt_q == CNT_LAST)     mc_rel_d = 1'b1;
      else if (mc_cnt_q != CNT_MAX) mc_cnt_d = mc_cnt_q + CW'(1);
      else                          mc_cnt_d = mc_cnt_q;
    end
  end

  // Multi-cycle counter and one-shot release flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      mc_cnt_q <= '0;
      mc_rel_q <= 1'b0;
    end else begin
      mc_cnt_q <= mc_cnt_d;
      mc_rel_q <= mc_rel_d;
    end
  end

  // Output decode; reset forces a fully flushed, unstalled pipeline
  always_comb begin
    hif.Stall_F    = 1'b0;
    hif.Stall_D    = 1'b0;
    hif.Stall_E    = 1'b0;
    hif.Flush_D    = 1'b1;
    hif.Flush_E    = 1'b1;
    hif.Flush_M    = 1'b1;
    hif.ForwardA_E = FWD_RF;
    hif.ForwardB_E = FWD_RF;
    hif.MC_Busy    = 1'b0;
    if (reset) begin
      hif.Stall_F    = (lw_stall && !redir) || mc_stall;
      hif.Stall_D    = lw_stall || mc_stall;
      hif.Stall_E    = mc_stall;
      hif.Flush_D    = redir || flush_hold;
      hif.Flush_E    = (lw_stall || redir) && !mc_stall;
      hif.Flush_M    = mc_stall;
      hif.ForwardA_E = fwd_a;
      hif.ForwardB_E = fwd_b;
      hif.MC_Busy    = mc_stall;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Randomized bench for hazard_unit_mc with a cycle-level behavioural model
// plus directed scenarios pinned to literal expectations.
module tb_hazard_unit_mc;
  localparam int AW        = 5;
  localparam int FETCH_LAT = 2;
  localparam int MC_LAT    = 4;
  localparam int FAR       = 1000;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  bit   chk_en = 0;

  // Model state: age of the op sitting in E, cycles since the last redirect
  int   m_age   = 0;
  int   m_since = FAR;

  hazard_unit_mc_if #(.AW(AW)) hif ();

  hazard_unit_mc #(.AW(AW), .FETCH_LAT(FETCH_LAT), .MC_LAT(MC_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
    if (rs == 0) return 2'b00;
    if (hif.RegWrite_M && rs == hif.Rd_M) return 2'b10;
    if (hif.RegWrite_W && rs == hif.Rd_W) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_redir();
    return hif.PCSrc_E != 2'b00;
  endfunction

  // An op stalls until it has spent MC_LAT-1 cycles in E
  function automatic bit m_mcs();
    return hif.MCStart_E && !m_redir() && (m_age < MC_LAT - 1);
  endfunction

  function automatic bit m_lw();
    bit e, m;
    e = hif.ResultSrc_E_0 && hif.Rd_E != 0 &&
        (hif.Rs1_D == hif.Rd_E || hif.Rs2_D == hif.Rd_E);
    m = hif.ResultSrc_M_0 && hif.Rd_M != 0 &&
        (hif.Rs1_D == hif.Rd_M || hif.Rs2_D == hif.Rd_M);
    return e || m;
  endfunction

  // Model state advance
  always @(posedge clk) begin
    if (!reset) begin
      m_age   = 0;
      m_since = FAR;
    end else begin
      if (m_mcs()) m_age = m_age + 1;
      else         m_age = 0;
      if (m_redir())          m_since = 1;
      else if (m_since < FAR) m_since = m_since + 1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [10:0] exp, act;
    bit r, mc, lw;
    if (chk_en) begin
      if (!reset) exp = 11'b000_111_00_00_0;
      else begin
        r  = m_redir();
        mc = m_mcs();
        lw = m_lw();
        exp = {(lw && !r) || mc, lw || mc, mc,
               r || (m_since <= FETCH_LAT), (lw || r) && !mc, mc,
               m_fwd(hif.Rs1_E), m_fwd(hif.Rs2_E), mc};
      end
      act = {hif.Stall_F, hif.Stall_D, hif.Stall_E, hif.Flush_D, hif.Flush_E,
             hif.Flush_M, hif.ForwardA_E, hif.ForwardB_E, hif.MC_Busy};
      cmp("model_outs", int'(act), int'(exp));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hif.Rs1_D = '0; hif.Rs2_D = '0; hif.Rs1_E = '0; hif.Rs2_E = '0;
    hif.Rd_E = '0; hif.Rd_M = '0; hif.Rd_W = '0; hif.PCSrc_E = 2'b00;
    hif.ResultSrc_E_0 = 0; hif.ResultSrc_M_0 = 0;
    hif.RegWrite_M = 0; hif.RegWrite_W = 0; hif.MCStart_E = 0;
  endtask

  initial begin
    bit pat [6] = '{1, 0, 1, 0, 0, 0};
    bit fde [6] = '{1, 1, 1, 1, 1, 0};
    clr();
    reset = 0;
    tick();
    chk_en = 1;
    // Reset override, even with a multi-cycle op requested
    hif.MCStart_E = 1;
    @(negedge clk);
    cmp("rst_flush_d", int'(hif.Flush_D), 1);
    cmp("rst_flush_m", int'(hif.Flush_M), 1);
    cmp("rst_stall_e", int'(hif.Stall_E), 0);
    cmp("rst_busy", int'(hif.MC_Busy), 0);
    tick(); reset = 1; clr();
    @(negedge clk);
    cmp("idle_flush_e", int'(hif.Flush_E), 0);

    // Forwarding priority
    tick();
    hif.Rs1_E = 5; hif.Rs2_E = 5; hif.Rd_M = 5; hif.Rd_W = 5;
    hif.RegWrite_M = 1; hif.RegWrite_W = 1;
    @(negedge clk);
    cmp("fwd_m_prio", int'(hif.ForwardA_E), 2);
    tick(); hif.Rs1_E = 0; hif.RegWrite_M = 0;
    @(negedge clk);
    cmp("fwd_x0", int'(hif.ForwardA_E), 0);
    cmp("fwd_w", int'(hif.ForwardB_E), 1);

    // Load-use
    tick(); clr();
    hif.ResultSrc_E_0 = 1; hif.Rd_E = 7; hif.Rs2_D = 7;
    @(negedge clk);
    cmp("lw_stall_f", int'(hif.Stall_F), 1);
    cmp("lw_stall_d", int'(hif.Stall_D), 1);
    cmp("lw_flush_e", int'(hif.Flush_E), 1);
    tick(); hif.Rd_E = 0; hif.Rs2_D = 0;
    @(negedge clk);
    cmp("lw_rd0_stall", int'(hif.Stall_D), 0);

    // Single redirect: 3 cycles of Flush_D, Flush_E only in the first
    tick(); clr(); hif.PCSrc_E = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmp("redir_flush_d", int'(hif.Flush_D), (i < 3) ? 1 : 0);
      cmp("redir_flush_e", int'(hif.Flush_E), (i == 0) ? 1 : 0);
      tick(); hif.PCSrc_E = 2'b00;
    end
    // Second redirect inside the window extends it
    for (int i = 0; i < 6; i++) begin
      hif.PCSrc_E = pat[i] ? 2'b01 : 2'b00;
      @(negedge clk);
      cmp("redir2_flush_d", int'(hif.Flush_D), int'(fde[i]));
      tick();
    end

    // Back-to-back multi-cycle ops
    hif.PCSrc_E = 2'b00; hif.MCStart_E = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cmp("mc_stall_e", int'(hif.Stall_E), (i % 4 != 3) ? 1 : 0);
      cmp("mc_flush_m", int'(hif.Flush_M), (i % 4 != 3) ? 1 : 0);
      tick();
    end

    // Load in D while the multi-cycle unit holds E
    clr(); tick();
    hif.MCStart_E = 1; hif.ResultSrc_E_0 = 1; hif.Rd_E = 3; hif.Rs1_D = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmp("mclw_stall_d", int'(hif.Stall_D), 1);
      cmp("mclw_flush_e", int'(hif.Flush_E), (i == 3) ? 1 : 0);
      tick();
    end

    // Reset in the second stall cycle
    clr(); tick();
    hif.MCStart_E = 1;
    @(negedge clk);
    cmp("mcr_stall1", int'(hif.Stall_E), 1);
    tick(); reset = 0;
    @(negedge clk);
    cmp("mcr_rst_stall", int'(hif.Stall_F), 0);
    cmp("mcr_rst_flush", int'(hif.Flush_E), 1);
    tick(); reset = 1; hif.MCStart_E = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cmp("mcr_after", int'(hif.Stall_E), 0);
      tick();
    end

    // Random traffic over a narrow register range to force matches
    for (int i = 0; i < 3000; i++) begin
      hif.Rs1_D = AW'($urandom_range(0, 3));
      hif.Rs2_D = AW'($urandom_range(0, 3));
      hif.Rs1_E = AW'($urandom_range(0, 3));
      hif.Rs2_E = AW'($urandom_range(0, 3));
      hif.Rd_E  = AW'($urandom_range(0, 3));
      hif.Rd_M  = AW'($urandom_range(0, 3));
      hif.Rd_W  = AW'($urandom_range(0, 3));
      hif.PCSrc_E = ($urandom_range(0, 99) < 8) ? 2'($urandom_range(1, 3)) : 2'b00;
      hif.ResultSrc_E_0 = ($urandom_range(0, 3) == 0);
      hif.ResultSrc_M_0 = ($urandom_range(0, 3) == 0);
      hif.RegWrite_M = $urandom_range(0, 1) == 1;
      hif.RegWrite_W = $urandom_range(0, 1) == 1;
      if (hif.MCStart_E) hif.MCStart_E = ($urandom_range(0, 9) < 8);
      else               hif.MCStart_E = ($urandom_range(0, 9) < 2);
      reset = ($urandom_range(0, 99) != 0);
      tick();
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W). It sits beside the datapath and drives the stall, flush and forward selects.
- Generalises the current hazard logic in three ways:
  - parametrised register-address width;
  - parametrised instruction-BRAM fetch latency, with Flush_D extended for that many cycles;
  - stalling for a multi-cycle execute unit (mul/div) that occupies E for MC_LAT cycles.
- Load-use stalls (load in E or M) and M-over-W forwarding priority are retained.

Parameters:
- AW, 5, register address width; register 0 is hardwired zero.
- FETCH_LAT, 1, extra cycles Flush_D is held after a redirect (0..4).
- MC_LAT, 4, total cycles a multi-cycle op occupies E (1..16); 1 means no stall.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- Rs1_D, Rs2_D  in  AW  source registers of the instruction in D.
- Rs1_E, Rs2_E, Rd_E  in  AW  source and destination registers in E.
- Rd_M, Rd_W  in  AW  destination registers in M and W.
- PCSrc_E  in  2  redirect select; nonzero means a taken branch/jump in E.
- ResultSrc_E_0, ResultSrc_M_0  in  1  the instruction in E/M is a load.
- RegWrite_M, RegWrite_W  in  1  M/W will write Rd.
- MCStart_E  in  1  the instruction in E is a multi-cycle op.
- Stall_F, Stall_D, Stall_E  out  1  hold the PC, the D register and the E register.
- Flush_D, Flush_E, Flush_M  out  1  bubble the D, E and M registers.
- ForwardA_E, ForwardB_E  out  2  operand select: 00 = register file, 01 = W, 10 = M.
- MC_Busy  out  1  the multi-cycle unit is holding E.

Behaviour:
- Reset (reset==0 at a clock edge): flush shift register = 0, mc_cnt = 0, mc_release = 0.
- Combinational override while reset==0:
  - Flush_D, Flush_E and Flush_M = 1;
  - all Stall_* = 0;
  - Forward* = 00;
  - MC_Busy = 0.
- Forwarding, per operand X in {A,B}:
  - 10 if Rs_E==Rd_M && RegWrite_M && Rs_E!=0;
  - else 01 if Rs_E==Rd_W && RegWrite_W && Rs_E!=0;
  - else 00.
- Load-use:
  - lwStall = (ResultSrc_E_0 && Rd_E!=0 && (Rs1_D==Rd_E || Rs2_D==Rd_E)) || (ResultSrc_M_0 && Rd_M!=0 && (Rs1_D==Rd_M || Rs2_D==Rd_M)).
- Redirect:
  - redir = |PCSrc_E.
  - flush_sr is a FETCH_LAT-bit shift register; redir shifts in at bit 0 each cycle.
  - Flush_D = redir || |flush_sr, so Flush_D is held for FETCH_LAT cycles after the last redir.
  - A redir arriving inside the window extends the window.
- Multi-cycle op:
  - mc_stall = MCStart_E && !mc_release && (MC_LAT>1) && !redir.
  - mc_cnt update:
    - while mc_stall, mc_cnt increments;
    - when mc_stall && mc_cnt==MC_LAT-2, the next cycle has mc_release=1 and mc_cnt=0;
    - mc_release clears after exactly one cycle.
  - Net effect: E holds the op for MC_LAT cycles, i.e. MC_LAT-1 stall cycles.
  - Back-to-back multi-cycle ops each stall independently.
  - MC_Busy = mc_stall.
- Outputs:
  - Stall_F = (lwStall && !redir) || mc_stall.
  - Stall_D = lwStall || mc_stall.
  - Stall_E = mc_stall.
  - Flush_E = (lwStall || redir) && !mc_stall.
  - Flush_M = mc_stall.
- Simultaneous events:
  - redir has priority over mc_stall and forces mc_cnt=0 and mc_release=0 (defensive; decode never issues both).
  - lwStall during mc_stall leaves D and E held with no Flush_E.
- Reset mid multi-cycle op: state clears and no stall is asserted after reset is released.
- Widths: mc_cnt is clog2(MC_LAT)+1 bits and saturates; no wrap is reachable.

Decomposition:
- Package hazard_pkg:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - PCSRC_SEQ=2'b00;
  - parameter range checks for FETCH_LAT and MC_LAT.
- Sub-module hazard_fwd_sel (Rs, Rd_M, Rd_W, RegWrite_M, RegWrite_W → 2-bit select), instantiated for A and B.
- Counter, release flag and flush shift register stay in the top module.

Test Plan:
- Forwarding priority: Rs1_E=5, Rd_M=5, Rd_W=5, both RegWrite=1 → ForwardA_E=10. With Rs1_E=0 → 00.
- Load-use: ResultSrc_E_0=1, Rd_E=7, Rs2_D=7 → Stall_F=Stall_D=Flush_E=1 for one cycle. The same case with Rd_E=0 → no stall.
- Redirect, FETCH_LAT=2: PCSrc_E=01 for one cycle → Flush_D=1 for 3 consecutive cycles and Flush_E=1 in the first cycle only. A second redirect in cycle 2 → Flush_D held through cycle 4.
- Multi-cycle op, MC_LAT=4: MCStart_E held → Stall_F/D/E=1 and Flush_M=1 for exactly 3 cycles, then 0 in the release cycle. A second op right after → 3 more stall cycles.
- Load in D during a multi-cycle stall: Stall_D=1 and Flush_E=0 throughout.
- Reset (reset=0) asserted in the 2nd stall cycle → all stalls 0 and flushes 1 while low. After release with MCStart_E=0 → no residual stall.
